// File: rtl/systolic_feed_ctrl.sv
// Sequencer for a west/north dual-bank systolic input buffer: load via DMA, then lock-step feed, drain, done.
// Latency: one DMA word written per cycle in LOAD; read data valid one cycle after each read; done DRAIN_CYCLES after last read.
// Backpressure: dma_ready held only in LOAD; reads stall (address holds) whenever tile_ready or either bank valid is low.
module systolic_feed_ctrl #(
    parameter int ADDR_WIDTH     = 5,
    parameter int BRAM_INDEX     = 1,
    parameter int DMA_DATA_WIDTH = 32,
    parameter int DRAIN_CYCLES   = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [ADDR_WIDTH:0]              num_words,
    output logic                             busy,
    output logic                             done,
    input  logic                             dma_valid,
    output logic                             dma_ready,
    input  logic [DMA_DATA_WIDTH-1:0]        dma_data,
    output logic                             buf_in_valid,
    output logic [BRAM_INDEX+ADDR_WIDTH-1:0] buf_in_addr,
    output logic [DMA_DATA_WIDTH-1:0]        buf_in_data,
    input  logic                             buf_out1_valid,
    input  logic                             buf_out2_valid,
    output logic                             buf_out1_ready,
    output logic                             buf_out2_ready,
    output logic [4:0]                       buf_out1_addr,
    output logic [4:0]                       buf_out2_addr,
    input  logic                             tile_ready,
    output logic                             tile_valid,
    output logic                             tile_last
);

    // Counters carry two extra bits so 2n (up to twice the bank depth) never wraps.
    localparam int CW = ADDR_WIDTH + 2;
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CW-1:0] DEPTH = CW'(2 ** ADDR_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   n;
    logic [CW-1:0]   wr_cnt;
    logic [CW-1:0]   rd_cnt;
    logic [DW-1:0]   drain_cnt;

    logic                  wr_fire;
    logic                  rd_fire;
    logic                  wr_west;
    logic [CW-1:0]         num_ext;
    logic [CW-1:0]         n_clamp;
    logic [CW-1:0]         n2;
    logic [BRAM_INDEX-1:0] wr_bank;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [4:0]            rd_addr;

    assign wr_fire = dma_valid & dma_ready;
    assign rd_fire = (state == S_FEED) & tile_ready & buf_out1_valid & buf_out2_valid;
    assign num_ext = CW'(num_words);
    assign n_clamp = (num_ext > DEPTH) ? DEPTH : num_ext;
    assign n2      = n << 1;

    // First n words land in the west bank, the next n in the north bank.
    assign wr_west = (wr_cnt < n);
    assign wr_bank = wr_west ? '0 : BRAM_INDEX'(1);
    assign wr_idx  = ADDR_WIDTH'(wr_west ? wr_cnt : (wr_cnt - n));

    assign buf_in_valid = wr_fire;
    assign buf_in_addr  = wr_fire ? {wr_bank, wr_idx} : '0;
    assign buf_in_data  = wr_fire ? dma_data : '0;

    // Both banks are always read together at the same address.
    assign rd_addr        = 5'(rd_cnt);
    assign buf_out1_ready = rd_fire;
    assign buf_out2_ready = rd_fire;
    assign buf_out1_addr  = (state == S_FEED) ? rd_addr : 5'd0;
    assign buf_out2_addr  = (state == S_FEED) ? rd_addr : 5'd0;

    // Job sequencer: state, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            n          <= '0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            drain_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dma_ready  <= 1'b0;
            tile_valid <= 1'b0;
            tile_last  <= 1'b0;
        end else begin
            // Read data from the banks appears one cycle after the read strobe.
            tile_valid <= rd_fire;
            tile_last  <= rd_fire && (rd_cnt == n - CW'(1));

            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        n      <= n_clamp;
                        wr_cnt <= '0;
                        rd_cnt <= '0;
                        busy   <= 1'b1;
                        if (n_clamp == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= S_LOAD;
                            dma_ready <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (wr_fire) begin
                        wr_cnt <= wr_cnt + CW'(1);
                        if (wr_cnt == n2 - CW'(1)) begin
                            dma_ready <= 1'b0;
                            state     <= S_FEED;
                        end
                    end
                end
                S_FEED: begin
                    if (rd_fire) begin
                        rd_cnt <= rd_cnt + CW'(1);
                        if (rd_cnt == n - CW'(1)) begin
                            drain_cnt <= '0;
                            state     <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl: runs load/feed/drain jobs and checks addresses, timing and pulses.
// Inputs are driven 1 ns after the rising edge; outputs are recorded on the falling edge.
// Event timestamps are the count of rising edges seen so far.
module tb_systolic_feed_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  num_words;
    logic        busy, done;
    logic        dma_valid, dma_ready;
    logic [31:0] dma_data;
    logic        buf_in_valid;
    logic [5:0]  buf_in_addr;
    logic [31:0] buf_in_data;
    logic        buf_out1_valid, buf_out2_valid;
    logic        buf_out1_ready, buf_out2_ready;
    logic [4:0]  buf_out1_addr, buf_out2_addr;
    logic        tile_ready, tile_valid, tile_last;

    systolic_feed_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words),
        .busy(busy), .done(done),
        .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_data(dma_data),
        .buf_in_valid(buf_in_valid), .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data),
        .buf_out1_valid(buf_out1_valid), .buf_out2_valid(buf_out2_valid),
        .buf_out1_ready(buf_out1_ready), .buf_out2_ready(buf_out2_ready),
        .buf_out1_addr(buf_out1_addr), .buf_out2_addr(buf_out2_addr),
        .tile_ready(tile_ready), .tile_valid(tile_valid), .tile_last(tile_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Event log of the current job
    logic [5:0] wr_addr[$];
    int         wr_cyc[$];
    logic [4:0] rd_addr[$];
    int         rd_cyc[$];
    int         tv_cyc[$];
    int         tl_cyc[$];
    int         last_dr;
    int         done_at;
    int         acc_cyc;
    bit         mon = 0;
    bit         in_stall = 0;

    always @(negedge clk) begin
        if (rst && mon) begin
            if (buf_in_valid) begin
                wr_addr.push_back(buf_in_addr);
                wr_cyc.push_back(cyc);
                chk("wr_data", buf_in_data, dma_data);
            end
            if (buf_out1_ready) begin
                rd_addr.push_back(buf_out1_addr);
                rd_cyc.push_back(cyc);
            end
            if (tile_valid) tv_cyc.push_back(cyc);
            if (tile_last)  tl_cyc.push_back(cyc);
            if (dma_ready)  last_dr = cyc;
            if (busy)
                chk("rd_pair", {buf_out1_ready, buf_out1_addr}, {buf_out2_ready, buf_out2_addr});
            if (in_stall) begin
                chk("stall_rdy", {buf_out1_ready, buf_out2_ready}, 2'b00);
                chk("stall_addr", buf_out1_addr, 5'd2);
            end
        end
    end

    function automatic logic [31:0] out_vec();
        return {busy, done, dma_ready, buf_in_valid, buf_out1_ready, buf_out2_ready,
                tile_valid, tile_last, buf_out1_addr, buf_out2_addr, buf_in_addr};
    endfunction

    // vmode: 0 dma_valid held high, 1 toggling. stall: insert FEED stalls after 2 reads.
    // extra_start: pulse start in LOAD and in the DONE cycle. abort: reset once 2 reads are seen.
    task automatic run_job(input logic [5:0] nw, input int vmode, input int stall,
                           input int extra_start, input int abort);
        int stall_k = 0;
        bit finished = 0;
        wr_addr.delete(); wr_cyc.delete(); rd_addr.delete(); rd_cyc.delete();
        tv_cyc.delete(); tl_cyc.delete();
        last_dr = -1; done_at = -1;
        @(posedge clk); #1;
        mon = 1; start = 1'b1; num_words = nw;
        @(posedge clk); #1;
        start = 1'b0;
        acc_cyc = cyc;
        chk("busy_on", busy, 1'b1);
        for (int k = 0; k < 400; k++) begin
            if (done) begin
                finished = 1;
                break;
            end
            dma_valid      = (vmode == 0) ? 1'b1 : ((k % 2) == 0);
            dma_data       = 32'hA500_0000 + 32'(k);
            tile_ready     = 1'b1;
            buf_out1_valid = 1'b1;
            buf_out2_valid = 1'b1;
            in_stall       = 1'b0;
            start          = (extra_start != 0) && (k == 2);
            if (stall != 0 && rd_addr.size() == 2 && stall_k < 5) begin
                in_stall = 1'b1;
                if (stall_k < 3) tile_ready = 1'b0;
                else             buf_out2_valid = 1'b0;
                stall_k++;
            end
            if (abort != 0 && rd_addr.size() == 2) begin
                rst = 1'b0;
                @(posedge clk); #1;
                chk("rst_mid_feed", out_vec(), 32'h0);
                rst = 1'b1;
                finished = 1;
                break;
            end
            @(posedge clk); #1;
        end
        in_stall = 1'b0;
        start = 1'b0;
        if (!finished) chk("timeout", 32'd0, 32'd1);
        if (finished && abort == 0) begin
            done_at = cyc;
            chk("busy_at_done", busy, 1'b1);
            start = (extra_start != 0);
            @(posedge clk); #1;
            start = 1'b0;
            chk("done_pulse", {done, busy}, 2'b00);
            @(posedge clk); #1;
            chk("idle_hold", {done, busy}, 2'b00);
        end
        dma_valid = 1'b0;
        mon = 0;
    endtask

    task automatic check_job(input int n);
        chk("wr_cnt", wr_addr.size(), 2 * n);
        for (int i = 0; i < wr_addr.size() && i < 2 * n; i++)
            chk("wr_addr", wr_addr[i], (i < n) ? i : 32 + i - n);
        chk("rd_cnt", rd_addr.size(), n);
        chk("tv_cnt", tv_cyc.size(), n);
        for (int i = 0; i < rd_addr.size() && i < n; i++) begin
            chk("rd_addr", rd_addr[i], i);
            if (i < tv_cyc.size()) chk("tv_lag", tv_cyc[i], rd_cyc[i] + 1);
        end
        chk("tl_cnt", tl_cyc.size(), (n > 0) ? 1 : 0);
        if (n > 0 && rd_cyc.size() == n) begin
            if (tl_cyc.size() == 1) chk("tl_when", tl_cyc[0], rd_cyc[n-1] + 1);
            chk("done_when", done_at, rd_cyc[n-1] + 17);
        end
        if (n > 0 && wr_cyc.size() > 0)
            chk("dma_rdy_end", last_dr, wr_cyc[wr_cyc.size()-1]);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; num_words = '0;
        dma_valid = 1'b0; dma_data = '0;
        buf_out1_valid = 1'b1; buf_out2_valid = 1'b1; tile_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", out_vec(), 32'h0);
        rst = 1'b1;

        // n=4, continuous DMA: exact write/read timing
        run_job(6'd4, 0, 0, 0, 0);
        check_job(4);
        if (wr_cyc.size() == 8) begin
            chk("t1_wr_first", wr_cyc[0], acc_cyc);
            chk("t1_wr_last", wr_cyc[7], acc_cyc + 7);
        end
        if (rd_cyc.size() == 4) begin
            chk("t1_rd_first", rd_cyc[0], acc_cyc + 8);
            chk("t1_rd_last", rd_cyc[3], acc_cyc + 11);
        end
        chk("t1_done_at", done_at, acc_cyc + 28);

        // n=32, DMA valid every other cycle
        run_job(6'd32, 1, 0, 0, 0);
        check_job(32);
        if (wr_addr.size() == 64) begin
            chk("t2_last_west", wr_addr[31], 6'h1F);
            chk("t2_last_north", wr_addr[63], 6'h3F);
        end

        // n=8 with tile_ready and north-valid stalls
        run_job(6'd8, 0, 1, 0, 0);
        check_job(8);
        if (rd_cyc.size() == 8) chk("t3_rd_span", rd_cyc[7] - rd_cyc[0], 7 + 5);

        // n=0 completes immediately; n=40 clamps to 32
        run_job(6'd0, 0, 0, 0, 0);
        check_job(0);
        chk("t4_zero_done", done_at, acc_cyc);
        run_job(6'd40, 0, 0, 0, 0);
        check_job(32);

        // reset during FEED, then a normal n=1 job
        run_job(6'd8, 0, 0, 0, 1);
        chk("t5_rd_before_rst", rd_addr.size(), 2);
        run_job(6'd1, 0, 0, 0, 0);
        check_job(1);

        // start pulsed during LOAD and DONE is ignored
        run_job(6'd4, 0, 0, 1, 0);
        check_job(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
